// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared 7-segment definitions. Provides the segment bus type, the
//            16 hex digit codes and the blank code used by both the display
//            encoder and the scan decoder, plus the scan FSM state type.
// Contents : seg_t, SEG_0..SEG_F, SEG_BLANK, scan_state_t
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  // Segment bus: bit 6 = A ... bit 0 = G, active-high.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h7B;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h1F;
  localparam seg_t SEG_C     = 7'h4E;
  localparam seg_t SEG_D     = 7'h3D;
  localparam seg_t SEG_E     = 7'h4F;
  localparam seg_t SEG_F     = 7'h47;
  localparam seg_t SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } scan_state_t;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_lookup.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_lookup
// Purpose  : Combinational inverse of the hex-to-segment encoder. Maps a
//            segment pattern back to its hex value.
// Ports    : seg   in  7  segment pattern
//            value out 4  decoded hex value (0 when not a legal digit)
//            hit   out 1  pattern is one of the 16 legal digit codes
//            blank out 1  pattern is the all-off blank code
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_lookup
  import seven_seg_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] value,
  output logic       hit,
  output logic       blank
);

  always_comb begin
    value = 4'h0;
    hit   = 1'b1;
    blank = (seg == SEG_BLANK);
    case (seg)
      SEG_0:   value = 4'h0;
      SEG_1:   value = 4'h1;
      SEG_2:   value = 4'h2;
      SEG_3:   value = 4'h3;
      SEG_4:   value = 4'h4;
      SEG_5:   value = 4'h5;
      SEG_6:   value = 4'h6;
      SEG_7:   value = 4'h7;
      SEG_8:   value = 4'h8;
      SEG_9:   value = 4'h9;
      SEG_A:   value = 4'hA;
      SEG_B:   value = 4'hB;
      SEG_C:   value = 4'hC;
      SEG_D:   value = 4'hD;
      SEG_E:   value = 4'hE;
      SEG_F:   value = 4'hF;
      default: hit   = 1'b0;
    endcase
  end

endmodule : seven_seg_lookup
`default_nettype wire

// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_decoder
// Purpose  : Loopback monitor for a multiplexed 7-segment bus. Synchronizes
//            segments and digit selects, waits for a stable pattern on a
//            one-hot select, then decodes it back into a per-digit nibble and
//            flags illegal patterns.
// Params   : NUM_DIGITS    number of multiplexed digits (1..8)
//            STABLE_CYCLES identical samples required before decode (>= 2)
// Ports    : i_Clk, i_Rst_L (async, active-low)
//            i_Segments    in  7           segment lines, bit 6 = A
//            i_Digit_Sel   in  NUM_DIGITS  one-hot digit enable
//            o_Digits      out 4*NUM_DIGITS decoded nibbles, digit k at [4k+:4]
//            o_Digit_Valid out NUM_DIGITS  digit holds a legal value
//            o_Update      out 1           decode completed pulse
//            o_Update_Idx  out 3           digit index of o_Update
//            o_Bad_Pattern out 1           decode found an illegal pattern
//            o_Err_Count   out 8           saturating illegal-pattern count
// Macro    : SEG_DEC_ERR_CNT_EN - implements the error counter; when
//            undefined o_Err_Count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  seg_t                    i_Segments,
  input  logic [NUM_DIGITS-1:0]   i_Digit_Sel,
  output logic [4*NUM_DIGITS-1:0] o_Digits,
  output logic [NUM_DIGITS-1:0]   o_Digit_Valid,
  output logic                    o_Update,
  output logic [2:0]              o_Update_Idx,
  output logic                    o_Bad_Pattern,
  output logic [7:0]              o_Err_Count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  // Two-flop synchronizer (meta -> s) and previous-sample register (p).
  seg_t                  seg_meta, seg_s, seg_p;
  logic [NUM_DIGITS-1:0] sel_meta, sel_s, sel_p;

  scan_state_t           state;
  logic [CNT_W-1:0]      cnt;

  logic                  sel_onehot;
  logic                  same_sample;
  logic [2:0]            sel_idx;
  logic                  decode_fire;
  logic                  bad_fire;

  logic [3:0]            lk_value;
  logic                  lk_hit;
  logic                  lk_blank;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      seg_meta <= '0;
      sel_meta <= '0;
      seg_s    <= '0;
      sel_s    <= '0;
      seg_p    <= '0;
      sel_p    <= '0;
    end else begin
      seg_meta <= i_Segments;
      sel_meta <= i_Digit_Sel;
      seg_s    <= seg_meta;
      sel_s    <= sel_meta;
      seg_p    <= seg_s;
      sel_p    <= sel_s;
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign sel_onehot  = (sel_s != '0) && ((sel_s & (sel_s - 1'b1)) == '0);
  assign same_sample = (seg_s == seg_p) && (sel_s == sel_p);

  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_s[k]) sel_idx = 3'(k);
    end
  end

  seven_seg_lookup u_lookup (
    .seg   (seg_s),
    .value (lk_value),
    .hit   (lk_hit),
    .blank (lk_blank)
  );

  // The sample that brings cnt to STABLE_CYCLES is the locking one.
  assign decode_fire = sel_onehot && same_sample && (state == ST_SETTLE) &&
                       (cnt == CNT_W'(STABLE_CYCLES - 1));
  assign bad_fire    = decode_fire && !lk_hit && !lk_blank;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      o_Digits      <= '0;
      o_Digit_Valid <= '0;
      o_Update      <= 1'b0;
      o_Update_Idx  <= '0;
      o_Bad_Pattern <= 1'b0;
    end else begin
      o_Update      <= 1'b0;
      o_Bad_Pattern <= 1'b0;
      if (!sel_onehot) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (!same_sample) begin
        state <= ST_SETTLE;
        cnt   <= CNT_W'(1);
      end else begin
        case (state)
          ST_SETTLE: begin
            if (decode_fire) begin
              state         <= ST_LOCKED;
              cnt           <= CNT_W'(STABLE_CYCLES);
              o_Update      <= 1'b1;
              o_Update_Idx  <= sel_idx;
              o_Bad_Pattern <= bad_fire;
              for (int k = 0; k < NUM_DIGITS; k++) begin
                if (sel_s[k]) begin
                  // Blank and illegal both leave the stored nibble alone.
                  if (lk_hit) begin
                    o_Digits[4*k +: 4] <= lk_value;
                    o_Digit_Valid[k]   <= 1'b1;
                  end else begin
                    o_Digit_Valid[k]   <= 1'b0;
                  end
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= state;
            cnt   <= cnt;
          end
        endcase
      end
    end
  end

`ifdef SEG_DEC_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      err_cnt <= '0;
    end else if (bad_fire && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign o_Err_Count = err_cnt;
`else
  assign o_Err_Count = '0;
`endif

endmodule : seven_seg_scan_decoder
`default_nettype wire
